// File: rtl/fpmul_pkg.sv
// Shared FP16 constants and pipeline payload types for the multiplier back end.
package fpmul_pkg;

    localparam int PROD_W   = 22;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 10;
    localparam int LZ_W     = 5;
    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

    localparam logic [15:0] QNAN = 16'h7E00;

    typedef struct packed {
        logic                     sign;
        logic [PROD_W-1:0]        norm;
        logic signed [EXP_W-1:0]  exp1;
        logic                     nan;
        logic                     inf;
        logic                     zero;
    } s1_payload_t;

    typedef struct packed {
        logic [15:0] result;
        logic        overflow;
        logic        underflow;
        logic        inexact;
    } s2_result_t;

endpackage

// File: rtl/leading_zero_counter.sv
// Counts leading zeros of a vector; an all-zero input returns DATA_WIDTH.
module leading_zero_counter #(
    parameter int DATA_WIDTH  = 22,
    parameter int COUNT_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [COUNT_WIDTH-1:0] count
);

    always_comb begin
        count = COUNT_WIDTH'(DATA_WIDTH);
        // Ascending scan: the highest set bit is the last one to write count.
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data[i]) begin
                count = COUNT_WIDTH'(DATA_WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpmul_norm_round.sv
// Two-stage normalise / round-to-nearest-even / pack back end of the FP16 multiplier.
module fpmul_norm_round
    import fpmul_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_W,
    parameter int EXP_WIDTH  = EXP_W,
    parameter int MAN_WIDTH  = MAN_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sign,
    input  logic signed [EXP_WIDTH-1:0] in_exp_sum,
    input  logic [PROD_WIDTH-1:0]       in_prod,
    input  logic                        in_nan,
    input  logic                        in_inf,
    input  logic                        in_zero,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MAN_WIDTH+5:0]        out_result,
    output logic                        out_overflow,
    output logic                        out_underflow,
    output logic                        out_inexact
);

    localparam logic signed [EXP_W:0] E_OVF = (EXP_W+1)'(EXP_MAX);
    localparam logic signed [EXP_W:0] E_UNF = '0;

    // Round-to-nearest-even on the normalised product and pack to binary16.
    function automatic s2_result_t round_pack(input s1_payload_t p);
        logic [MAN_W-1:0]      frac;
        logic                  guard;
        logic                  sticky;
        logic                  up;
        logic [MAN_W:0]        frac_r;
        logic signed [EXP_W:0] e;
        s2_result_t            r;

        frac   = p.norm[PROD_W-2 -: MAN_W];
        guard  = p.norm[PROD_W-2-MAN_W];
        sticky = |p.norm[PROD_W-3-MAN_W:0];
        up     = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, up};
        // A fraction carry bumps the exponent before the range check.
        e      = {p.exp1[EXP_W-1], p.exp1} + {{EXP_W{1'b0}}, frac_r[MAN_W]};

        r = '0;
        if (p.nan) begin
            r.result = QNAN;
        end else if (p.inf) begin
            r.result = {p.sign, 15'h7C00};
        end else if (p.zero || !p.norm[PROD_W-1]) begin
            r.result = {p.sign, 15'h0000};
        end else if (e >= E_OVF) begin
            r.result   = {p.sign, 5'h1F, {MAN_W{1'b0}}};
            r.overflow = 1'b1;
            r.inexact  = 1'b1;
        end else if (e <= E_UNF) begin
            r.result    = {p.sign, 15'h0000};
            r.underflow = 1'b1;
            r.inexact   = 1'b1;
        end else begin
            r.result  = {p.sign, e[4:0], frac_r[MAN_W-1:0]};
            r.inexact = guard | sticky;
        end
        return r;
    endfunction

    logic [LZ_W-1:0] lz;
    s1_payload_t     pay_n;
    s1_payload_t     pay_p1;
    logic            vld_p1;
    logic            s2_free;
    s2_result_t      res_p2;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !vld_p1 || s2_free;

    // ---- stage 1: normalise ----
    leading_zero_counter #(
        .DATA_WIDTH  (PROD_WIDTH),
        .COUNT_WIDTH (LZ_W)
    ) u_lzc (
        .data  (in_prod),
        .count (lz)
    );

    always_comb begin
        pay_n      = '0;
        pay_n.sign = in_sign;
        pay_n.norm = in_prod << lz;
        pay_n.exp1 = in_exp_sum + EXP_WIDTH'(1) - EXP_WIDTH'(lz);
        pay_n.nan  = in_nan;
        pay_n.inf  = in_inf;
        pay_n.zero = in_zero;
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            pay_p1 <= pay_n;
        end
    end

    // ---- stage 2: round and pack ----
    assign res_p2 = round_pack(pay_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (s2_free) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    out_result    <= res_p2.result;
                    out_overflow  <= res_p2.overflow;
                    out_underflow <= res_p2.underflow;
                    out_inexact   <= res_p2.inexact;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpmul_norm_round.sv
// Directed-vector bench for the FP16 normalise/round back end.
module tb_fpmul_norm_round;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic signed [7:0] in_exp_sum;
    logic [21:0]       in_prod;
    logic              in_nan;
    logic              in_inf;
    logic              in_zero;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_result;
    logic              out_overflow;
    logic              out_underflow;
    logic              out_inexact;

    int n_cmp  = 0;
    int n_fail = 0;

    fpmul_norm_round dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp_sum    (in_exp_sum),
        .in_prod       (in_prod),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .in_zero       (in_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one item into an empty pipeline and waits for its result.
    // flags = {overflow, underflow, inexact}; lat = cycles from presentation, -1 on timeout.
    task automatic send_one(input logic sgn, input logic signed [7:0] es, input logic [21:0] pr,
                            input logic nan, input logic inf, input logic zer,
                            output logic [15:0] res, output logic [2:0] flags, output int lat);
        out_ready  = 1'b1;
        in_sign    = sgn;
        in_exp_sum = es;
        in_prod    = pr;
        in_nan     = nan;
        in_inf     = inf;
        in_zero    = zer;
        in_valid   = 1'b1;
        lat        = 0;
        res        = 16'h0;
        flags      = 3'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
        end while (!out_valid && lat < 10);
        if (out_valid) begin
            res   = out_result;
            flags = {out_overflow, out_underflow, out_inexact};
        end else begin
            lat = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if (out_result !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out_result: got %h expected 0000", out_result);
        end
        n_cmp++;
        if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {out_overflow, out_underflow, out_inexact});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] r;
        logic [2:0]  f;
        int          lat;
        send_one(1'b0, 8'sd15, 22'h240000, 1'b0, 1'b0, 1'b0, r, f, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL latency_1p5sq: got %0d expected 2", lat);
        end
        n_cmp++;
        if (r !== 16'h4080) begin
            n_fail++; $display("FAIL result_1p5sq: got %h expected 4080", r);
        end
        n_cmp++;
        if (f !== 3'b000) begin
            n_fail++; $display("FAIL flags_1p5sq: got %b expected 000", f);
        end
        send_one(1'b0, 8'sd15, 22'h100000, 1'b0, 1'b0, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 16'h3C00 || f !== 3'b000) begin
            n_fail++; $display("FAIL one_pos: got %h/%b expected 3c00/000", r, f);
        end
        send_one(1'b1, 8'sd15, 22'h100000, 1'b0, 1'b0, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 16'hBC00 || f !== 3'b000) begin
            n_fail++; $display("FAIL one_neg: got %h/%b expected bc00/000", r, f);
        end
    endtask

    task automatic test_rounding();
        logic [21:0] prod [3] = '{22'h200400, 22'h200C00, 22'h3FFC00};
        logic [15:0] expr [3] = '{16'h4000, 16'h4002, 16'h4400};
        logic [15:0] r;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            send_one(1'b0, 8'sd15, prod[i], 1'b0, 1'b0, 1'b0, r, f, lat);
            n_cmp++;
            if (r !== expr[i]) begin
                n_fail++; $display("FAIL round_result[%0d]: got %h expected %h", i, r, expr[i]);
            end
            n_cmp++;
            if (f !== 3'b001) begin
                n_fail++; $display("FAIL round_flags[%0d]: got %b expected 001", i, f);
            end
        end
    endtask

    task automatic test_range();
        logic [15:0] r;
        logic [2:0]  f;
        int          lat;
        send_one(1'b0, 8'sd30, 22'h200000, 1'b0, 1'b0, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 16'h7C00 || f !== 3'b101) begin
            n_fail++; $display("FAIL overflow: got %h/%b expected 7c00/101", r, f);
        end
        send_one(1'b1, 8'sd0, 22'h100000, 1'b0, 1'b0, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 16'h8000 || f !== 3'b011) begin
            n_fail++; $display("FAIL underflow: got %h/%b expected 8000/011", r, f);
        end
    endtask

    task automatic test_specials();
        logic [15:0] r;
        logic [2:0]  f;
        int          lat;
        send_one(1'b1, 8'sd15, 22'h240000, 1'b1, 1'b1, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 16'h7E00 || f !== 3'b000) begin
            n_fail++; $display("FAIL nan_over_inf: got %h/%b expected 7e00/000", r, f);
        end
        send_one(1'b1, 8'sd15, 22'h240000, 1'b0, 1'b1, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 16'hFC00 || f !== 3'b000) begin
            n_fail++; $display("FAIL inf_neg: got %h/%b expected fc00/000", r, f);
        end
        send_one(1'b1, 8'sd15, 22'h000000, 1'b0, 1'b0, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 16'h8000 || f !== 3'b000) begin
            n_fail++; $display("FAIL prod_zero: got %h/%b expected 8000/000", r, f);
        end
        send_one(1'b0, 8'sd0, 22'h3FFFFF, 1'b0, 1'b0, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 16'h0000 || f !== 3'b000) begin
            n_fail++; $display("FAIL zero_flag: got %h/%b expected 0000/000", r, f);
        end
    endtask

    task automatic test_back_to_back();
        int          idx = 0;
        int          rcv = 0;
        logic        fire_in;
        logic        have_held = 1'b0;
        logic [15:0] held = 16'h0;
        logic [15:0] expv;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            out_ready  = (c >= 4);
            in_valid   = (idx < 6);
            in_sign    = 1'b0;
            in_exp_sum = 8'sd15;
            in_prod    = 22'h200000 | (22'(idx + 1) << 11);
            in_nan     = 1'b0;
            in_inf     = 1'b0;
            in_zero    = 1'b0;
            #1;
            if (c < 4) begin
                n_cmp++;
                if (in_ready !== (idx < 2)) begin
                    n_fail++; $display("FAIL bp_in_ready[c%0d]: got %b expected %b", c, in_ready, (idx < 2));
                end
            end
            if (have_held) begin
                n_cmp++;
                if (out_result !== held) begin
                    n_fail++; $display("FAIL bp_hold[c%0d]: got %h expected %h", c, out_result, held);
                end
            end
            have_held = out_valid && !out_ready;
            held      = out_result;
            if (out_valid && out_ready) begin
                expv = 16'h4000 | 16'(rcv + 1);
                n_cmp++;
                if (out_result !== expv) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", rcv, out_result, expv);
                end
                rcv++;
            end
            fire_in = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire_in) idx++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (rcv !== 6 || idx !== 6) begin
            n_fail++; $display("FAIL bp_count: got %0d out/%0d in expected 6/6", rcv, idx);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready  = 1'b1;
        in_sign    = 1'b0;
        in_exp_sum = 8'sd15;
        in_prod    = 22'h240000;
        in_nan     = 1'b0;
        in_inf     = 1'b0;
        in_zero    = 1'b0;
        in_valid   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000) begin
            n_fail++; $display("FAIL mid_reset: got %b/%h expected 0/0000", out_valid, out_result);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL mid_discard: got %0d outputs expected 0", seen);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp_sum = 8'sd0;
        in_prod    = 22'h0;
        in_nan     = 1'b0;
        in_inf     = 1'b0;
        in_zero    = 1'b0;
        out_ready  = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
